booth_seq_mult_ctrl: RTL

Iterative radix-2 Booth multiplication sequencer. It accepts one signed WIDTH×WIDTH operand pair through a valid/ready handshake and retires one Booth step per clock over WIDTH cycles. It presents the signed 2·WIDTH-bit product through a second valid/ready handshake. It is the area-optimised sequential counterpart to the team's fully combinational Booth multiplier and uses one shared adder/subtractor instead of WIDTH partial-product rows.

---
 rtl/booth_seq_pkg.sv | 25 ++
 rtl/booth_seq_mult_ctrl_if.sv | 28 ++
 rtl/booth_step.sv | 41 ++++
 rtl/booth_seq_mult_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/booth_seq_pkg.sv
// booth_seq_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   state_t       - controller states (IDLE, RUN, DONE)
//   BOOTH_*       - encodings of the {Q_r[0], q_m1} Booth select pair
//   cnt_width()   - bits needed to hold a step count of 0..width
package booth_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // {Q_r[0], q_m1} pairs. Both 00 and 11 mean "no change to A".
    localparam logic [1:0] BOOTH_NOP     = 2'b00;
    localparam logic [1:0] BOOTH_NOP_ALT = 2'b11;
    localparam logic [1:0] BOOTH_ADD     = 2'b01;
    localparam logic [1:0] BOOTH_SUB     = 2'b10;

    // Step counter width: it is loaded with width itself, so width+1 codes are needed.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/booth_seq_mult_ctrl_if.sv
// booth_seq_mult_ctrl_if
// Operand and product handshakes of the sequential Booth multiplier.
//   in_valid/in_ready        - operand pair handshake (multiplicand, multiplier)
//   out_valid/out_ready      - product handshake (product, 2*WIDTH bits)
//   busy                     - multiplier is running or holding a result
// Modports: slave = multiplier side, master = client side.
interface booth_seq_mult_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_step.sv
// booth_step
// One combinational radix-2 Booth step: conditional add/subtract of the
// sign-extended multiplicand into A, then arithmetic right shift of
// {A, Q, q_m1} by one bit.
//   a_in/a_out     - WIDTH+1 bit accumulator (extra bit absorbs -(-2^(WIDTH-1)))
//   q_in/q_out     - multiplier shift register
//   qm1_in/qm1_out - bit shifted out of Q on the previous step
//   m_in           - multiplicand
module booth_step
    import booth_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             qm1_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qm1_out
);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign m_ext = {m_in[WIDTH-1], m_in};

    always_comb begin
        sum = a_in;
        case ({q_in[0], qm1_in})
            BOOTH_ADD: sum = a_in + m_ext;
            BOOTH_SUB: sum = a_in - m_ext;
            default:   sum = a_in;
        endcase
    end

    // Arithmetic shift: A's sign bit is replicated, A's LSB moves into Q.
    assign a_out   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_out   = {sum[0], q_in[WIDTH-1:1]};
    assign qm1_out = q_in[0];

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// booth_seq_mult_ctrl
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier. Accepts an
// operand pair in IDLE, retires one Booth step per clock for WIDTH clocks,
// then holds the 2*WIDTH-bit product in DONE until it is consumed.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - operand/product handshakes and busy (slave modport)
module booth_seq_mult_ctrl
    import booth_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_seq_mult_ctrl_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    state_t               state_reg, state_next;
    logic [WIDTH:0]       a_reg, a_next;
    logic [WIDTH-1:0]     q_reg, q_next;
    logic                 qm1_reg, qm1_next;
    logic [WIDTH-1:0]     m_reg, m_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic [WIDTH:0]       step_a;
    logic [WIDTH-1:0]     step_q;
    logic                 step_qm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_in    (a_reg),
        .q_in    (q_reg),
        .qm1_in  (qm1_reg),
        .m_in    (m_reg),
        .a_out   (step_a),
        .q_out   (step_q),
        .qm1_out (step_qm1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            qm1_reg     <= 1'b0;
            m_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            q_reg       <= q_next;
            qm1_reg     <= qm1_next;
            m_reg       <= m_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        q_next       = q_reg;
        qm1_next     = qm1_reg;
        m_next       = m_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = RUN;
                    m_next     = bus.multiplicand;
                    a_next     = '0;
                    q_next     = bus.multiplier;
                    qm1_next   = 1'b0;
                    cnt_next   = CNT_LOAD;
                end
            end
            RUN: begin
                a_next   = step_a;
                q_next   = step_q;
                qm1_next = step_qm1;
                cnt_next = cnt_reg - CNT_LAST;
                // Final step: the shifted A fits in WIDTH bits, so its top bit is dropped.
                if (cnt_reg == CNT_LAST) begin
                    state_next   = DONE;
                    product_next = {step_a[WIDTH-1:0], step_q};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.product   = product_reg;

endmodule
